piso_serializer_4b: RTL and testbench

//  Parallel-in/serial-out stage that feeds the serial input of the 4-bit SIPO shift register.

---
 rtl/piso_serializer_4b_if.sv | 20 ++
 rtl/piso_serializer_4b.sv | 71 +++++++
 tb/tb_piso_serializer_4b.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/piso_serializer_4b_if.sv
// piso_serializer_4b_if: producer handshake plus serial output bundle for the PISO stage
interface piso_serializer_4b_if #(
  parameter int WIDTH = 4
);
  logic [WIDTH-1:0] din_par;
  logic             din_valid;
  logic             din_ready;
  logic             dout;
  logic             dout_valid;
  logic             frame_start;
  logic             busy;
  modport master (
    output din_par, din_valid,
    input  din_ready, dout, dout_valid, frame_start, busy
  );
  modport slave (
    input  din_par, din_valid,
    output din_ready, dout, dout_valid, frame_start, busy
  );
endinterface

// File: rtl/piso_serializer_4b.sv
// piso_serializer_4b: FIFO-buffered parallel-in/serial-out shifter with per-word frame flag
module piso_serializer_4b #(
  parameter int WIDTH     = 4,
  parameter int DEPTH     = 2,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input logic                  clk,
  input logic                  reset,
  piso_serializer_4b_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state, state_nx;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] sreg, sreg_nx, head;
  logic [BW-1:0] bitcnt, bitcnt_nx;
  logic dout_q, dout_valid_q, frame_start_q;
  logic dout_nx, dout_valid_nx, frame_start_nx;
  logic empty, full, push, load, shift;
  assign empty = count == '0;
  assign full  = count == CW'(DEPTH);
  assign head  = mem[rd_ptr];
  // Ready drops with reset asynchronously so nothing is offered during reset
  assign bus.din_ready = reset & !full;
  assign push  = bus.din_valid & bus.din_ready;
  assign load  = !empty && (state == IDLE || bitcnt == '0);
  assign shift = state == SHIFT && bitcnt != '0;
  always_ff @(posedge clk or negedge reset)
    if (!reset) state <= IDLE;
    else state <= state_nx;
  always_comb state_nx = (!empty || shift) ? SHIFT : IDLE;
  always_comb begin
    sreg_nx        = load ? head : shift ? (MSB_FIRST ? sreg << 1 : sreg >> 1) : sreg;
    bitcnt_nx      = load ? BW'(WIDTH - 1) : shift ? bitcnt - 1'b1 : bitcnt;
    dout_nx        = load ? (MSB_FIRST ? head[WIDTH-1] : head[0]) :
                     shift ? (MSB_FIRST ? sreg[WIDTH-2] : sreg[1]) : IDLE_BIT;
    dout_valid_nx  = load | shift;
    frame_start_nx = load;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      count         <= '0;
      sreg          <= '0;
      bitcnt        <= '0;
      dout_q        <= IDLE_BIT;
      dout_valid_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      wr_ptr        <= push ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr        <= load ? rd_ptr + 1'b1 : rd_ptr;
      count         <= count + CW'(push) - CW'(load);
      sreg          <= sreg_nx;
      bitcnt        <= bitcnt_nx;
      dout_q        <= dout_nx;
      dout_valid_q  <= dout_valid_nx;
      frame_start_q <= frame_start_nx;
    end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= bus.din_par;
  assign bus.dout        = dout_q;
  assign bus.dout_valid  = dout_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.busy        = !empty || state == SHIFT;
endmodule

// File: tb/tb_piso_serializer_4b.sv
// tb_piso_serializer_4b: scoreboard bench for MSB-first and LSB-first serializer instances
module tb_piso_serializer_4b;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  piso_serializer_4b_if #(.WIDTH(4)) if0 ();
  piso_serializer_4b_if #(.WIDTH(4)) if1 ();
  piso_serializer_4b #(.MSB_FIRST(1'b1)) u0 (.clk(clk), .reset(reset), .bus(if0));
  piso_serializer_4b #(.MSB_FIRST(1'b0)) u1 (.clk(clk), .reset(reset), .bus(if1));
  int checks = 0;
  int failures = 0;
  logic [1:0] q0 [$];
  logic [1:0] q1 [$];
  logic pend0, pend1;
  logic [3:0] w0, w1, sipo;
  // Accept decisions are sampled mid-cycle; expected {frame_start, bit} pairs enqueue on the edge
  always @(negedge clk) begin
    pend0 = if0.din_valid & if0.din_ready;
    pend1 = if1.din_valid & if1.din_ready;
    w0 = if0.din_par;
    w1 = if1.din_par;
  end
  always @(posedge clk)
    if (reset) begin
      if (pend0) for (int i = 0; i < 4; i++) q0.push_back({i == 0, w0[3-i]});
      if (pend1) for (int i = 0; i < 4; i++) q1.push_back({i == 0, w1[i]});
    end
  always @(posedge clk or negedge reset)
    if (!reset) sipo <= 4'b0;
    else if (if0.dout_valid) sipo <= {sipo[2:0], if0.dout};
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (if0.dout !== 1'b0) begin failures++; $display("FAIL rst_dout got=%b exp=0", if0.dout); end
    checks++; if (if0.dout_valid !== 1'b0) begin failures++; $display("FAIL rst_dout_valid got=%b exp=0", if0.dout_valid); end
    checks++; if (if0.frame_start !== 1'b0) begin failures++; $display("FAIL rst_frame_start got=%b exp=0", if0.frame_start); end
    checks++; if (if0.din_ready !== 1'b0) begin failures++; $display("FAIL rst_din_ready got=%b exp=0", if0.din_ready); end
    checks++; if (if0.busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b exp=0", if0.busy); end
    reset = 1'b1;
    @(posedge clk); #1;
    if0.din_par = 4'b1111;
    if0.din_valid = 1'b1;
    @(posedge clk); #1;
    if0.din_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    checks++; if (if0.dout_valid !== 1'b1) begin failures++; $display("FAIL midrun_inflight got=%b exp=1", if0.dout_valid); end
    reset = 1'b0;
    #1;
    checks++; if (if0.dout !== 1'b0) begin failures++; $display("FAIL async_dout got=%b exp=0", if0.dout); end
    checks++; if (if0.dout_valid !== 1'b0) begin failures++; $display("FAIL async_dout_valid got=%b exp=0", if0.dout_valid); end
    checks++; if (if0.frame_start !== 1'b0) begin failures++; $display("FAIL async_frame_start got=%b exp=0", if0.frame_start); end
    checks++; if (if0.din_ready !== 1'b0) begin failures++; $display("FAIL async_din_ready got=%b exp=0", if0.din_ready); end
    checks++; if (if0.busy !== 1'b0) begin failures++; $display("FAIL async_busy got=%b exp=0", if0.busy); end
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask
  task automatic test_single();
    logic [1:0] e;
    logic [3:0] got = '0;
    int nv = 0, nfs = 0;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(posedge clk); #1;
      if0.din_par = (cyc == 0) ? 4'b1011 : 4'b0000;
      if0.din_valid = (cyc == 0);
      @(negedge clk);
      checks++;
      if (if0.dout_valid) begin
        nv++;
        nfs += int'(if0.frame_start);
        got = {got[2:0], if0.dout};
        if (q0.size() == 0) begin failures++; $display("FAIL single_sb got=%b%b exp=none", if0.frame_start, if0.dout); end
        else begin
          e = q0.pop_front();
          if ({if0.frame_start, if0.dout} !== e) begin failures++; $display("FAIL single_bit got=%b%b exp=%b", if0.frame_start, if0.dout, e); end
        end
      end else if (if0.dout !== 1'b0) begin failures++; $display("FAIL single_idle got=%b exp=0", if0.dout); end
    end
    checks++; if (got !== 4'b1011) begin failures++; $display("FAIL single_word got=%b exp=1011", got); end
    checks++; if (nv != 4) begin failures++; $display("FAIL single_nvalid got=%0d exp=4", nv); end
    checks++; if (nfs != 1) begin failures++; $display("FAIL single_nfs got=%0d exp=1", nfs); end
  endtask
  task automatic test_back_to_back();
    logic [3:0] words [3] = '{4'b1010, 4'b0110, 4'b1111};
    logic [1:0] e;
    logic [11:0] got = '0, fsm = '0;
    int nv = 0, first = -1, last = -1;
    for (int cyc = 0; cyc < 18; cyc++) begin
      @(posedge clk); #1;
      if0.din_par = (cyc < 3) ? words[cyc] : 4'b0000;
      if0.din_valid = (cyc < 3);
      @(negedge clk);
      if (if0.dout_valid) begin
        nv++;
        if (first < 0) first = cyc;
        last = cyc;
        got = {got[10:0], if0.dout};
        fsm = {fsm[10:0], if0.frame_start};
        checks++;
        if (q0.size() == 0) begin failures++; $display("FAIL b2b_sb got=%b%b exp=none", if0.frame_start, if0.dout); end
        else begin
          e = q0.pop_front();
          if ({if0.frame_start, if0.dout} !== e) begin failures++; $display("FAIL b2b_bit got=%b%b exp=%b", if0.frame_start, if0.dout, e); end
        end
      end
    end
    checks++; if (got !== 12'b1010_0110_1111) begin failures++; $display("FAIL b2b_stream got=%b exp=101001101111", got); end
    checks++; if (fsm !== 12'b1000_1000_1000) begin failures++; $display("FAIL b2b_frames got=%b exp=100010001000", fsm); end
    checks++; if (nv != 12 || last - first + 1 != 12) begin failures++; $display("FAIL b2b_contig got=%0d/%0d exp=12/12", nv, last - first + 1); end
  endtask
  task automatic test_backpressure();
    logic [1:0] e;
    logic [19:0] got = '0;
    logic acc = 1'b0;
    int k = 0, nv = 0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      @(posedge clk); #1;
      if (cyc == 0) begin if0.din_par = 4'd1; if0.din_valid = 1'b1; end
      else if (acc) begin k++; if0.din_par = 4'(k + 1); if0.din_valid = (k < 5); end
      @(negedge clk);
      if (if0.dout_valid) begin
        nv++;
        got = {got[18:0], if0.dout};
        checks++;
        if (q0.size() == 0) begin failures++; $display("FAIL bp_sb got=%b%b exp=none", if0.frame_start, if0.dout); end
        else begin
          e = q0.pop_front();
          if ({if0.frame_start, if0.dout} !== e) begin failures++; $display("FAIL bp_bit got=%b%b exp=%b", if0.frame_start, if0.dout, e); end
        end
      end
      if (cyc == 3) begin
        checks++; if (if0.din_ready !== 1'b0 || k != 3) begin failures++; $display("FAIL bp_full got=ready%b/acc%0d exp=ready0/acc3", if0.din_ready, k); end
      end
      if (cyc == 5) begin
        checks++; if (if0.din_ready !== 1'b0) begin failures++; $display("FAIL bp_hold got=%b exp=0", if0.din_ready); end
      end
      if (cyc == 6) begin
        checks++; if (if0.din_ready !== 1'b1) begin failures++; $display("FAIL bp_reopen got=%b exp=1", if0.din_ready); end
      end
      acc = if0.din_valid & if0.din_ready;
    end
    if0.din_valid = 1'b0;
    checks++; if (got !== 20'h12345 || nv != 20) begin failures++; $display("FAIL bp_stream got=%h/%0d exp=12345/20", got, nv); end
    checks++; if (q0.size() != 0) begin failures++; $display("FAIL bp_leftover got=%0d exp=0", q0.size()); end
  endtask
  task automatic test_loopback();
    logic [1:0] e;
    for (int cyc = 0; cyc < 9; cyc++) begin
      @(posedge clk); #1;
      if0.din_par = (cyc == 0) ? 4'b1100 : 4'b0000;
      if0.din_valid = (cyc == 0);
      @(negedge clk);
      if (if0.dout_valid) begin
        checks++;
        if (q0.size() == 0) begin failures++; $display("FAIL loop_sb got=%b%b exp=none", if0.frame_start, if0.dout); end
        else begin
          e = q0.pop_front();
          if ({if0.frame_start, if0.dout} !== e) begin failures++; $display("FAIL loop_bit got=%b%b exp=%b", if0.frame_start, if0.dout, e); end
        end
      end
    end
    checks++; if (sipo !== 4'b1100) begin failures++; $display("FAIL loop_sipo got=%b exp=1100", sipo); end
  endtask
  task automatic test_lsb_first();
    logic [1:0] e;
    logic [1:0] got = '0;
    int nb = 0;
    for (int cyc = 0; cyc < 10 && nb < 2; cyc++) begin
      @(posedge clk); #1;
      if1.din_par = (cyc == 0) ? 4'b0001 : 4'b0000;
      if1.din_valid = (cyc == 0);
      @(negedge clk);
      if (if1.dout_valid) begin
        nb++;
        got = {got[0], if1.dout};
        checks++;
        if (q1.size() == 0) begin failures++; $display("FAIL lsb_sb got=%b%b exp=none", if1.frame_start, if1.dout); end
        else begin
          e = q1.pop_front();
          if ({if1.frame_start, if1.dout} !== e) begin failures++; $display("FAIL lsb_bit got=%b%b exp=%b", if1.frame_start, if1.dout, e); end
        end
      end
    end
    checks++; if (nb != 2 || got !== 2'b10) begin failures++; $display("FAIL lsb_first2 got=%0d:%b exp=2:10", nb, got); end
    #1;
    reset = 1'b0;
    #1;
    checks++; if (if1.busy !== 1'b0 || if1.dout_valid !== 1'b0 || if1.dout !== 1'b0) begin
      failures++; $display("FAIL lsb_abort got=busy%b/valid%b/dout%b exp=0/0/0", if1.busy, if1.dout_valid, if1.dout); end
    q0.delete();
    q1.delete();
    @(negedge clk);
    reset = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checks++; if (if1.dout_valid !== 1'b0 || if1.busy !== 1'b0) begin
        failures++; $display("FAIL lsb_resume got=valid%b/busy%b exp=0/0", if1.dout_valid, if1.busy); end
    end
  endtask
  initial begin
    if0.din_par = '0;
    if0.din_valid = 1'b0;
    if1.din_par = '0;
    if1.din_valid = 1'b0;
    #2;
    test_reset();
    test_single();
    test_back_to_back();
    test_backpressure();
    test_loopback();
    test_lsb_first();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
